// File: rtl/bram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_arbiter_pkg
// Brief    : Shared types and helpers for the block-RAM arbiter.
// Revision : 1.0
// ============================================================================
package bram_arbiter_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Requester-id width; a single requester still needs one bit of id.
    function automatic int id_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter with grant-lock override.
// Revision : 1.0
// ============================================================================
module rr_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IDW-1:0]  i_ptr,
    input  logic            i_lock_valid,
    input  logic [IDW-1:0]  i_lock_id,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_grant_id
);

    logic [IDW:0] w_idx;
    logic         w_found;

    always_comb begin
        o_grant    = '0;
        o_grant_id = '0;
        w_idx      = '0;
        w_found    = 1'b0;
        if (i_lock_valid && i_valid[i_lock_id]) begin
            o_grant[i_lock_id] = 1'b1;
            o_grant_id         = i_lock_id;
        end else begin
            // Scan from the pointer upward, wrapping at NREQ.
            for (int k = 0; k < NREQ; k++) begin
                w_idx = {1'b0, i_ptr} + (IDW+1)'(k);
                if (w_idx >= (IDW+1)'(NREQ)) begin
                    w_idx = w_idx - (IDW+1)'(NREQ);
                end
                if (!w_found && i_valid[w_idx[IDW-1:0]]) begin
                    w_found                  = 1'b1;
                    o_grant[w_idx[IDW-1:0]]  = 1'b1;
                    o_grant_id               = w_idx[IDW-1:0];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bram_arbiter
// Brief    : Shares one block RAM between NREQ requesters; clears RAM after reset.
// Revision : 1.0
// ============================================================================
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int              NREQ       = 2,
    parameter int              ALEN       = 8,
    parameter int              DLEN       = 32,
    parameter logic [DLEN-1:0] INIT_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [NREQ*ALEN-1:0] req_addr,
    input  logic [NREQ*DLEN-1:0] req_wdata,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [DLEN-1:0]      rsp_rdata,
    output logic                 init_done,
    output logic                 mem_wen,
    output logic [ALEN-1:0]      mem_waddr,
    output logic [DLEN-1:0]      mem_wdata,
    output logic                 mem_ren,
    output logic [ALEN-1:0]      mem_raddr,
    input  logic [DLEN-1:0]      mem_rdata
);

    localparam int              IDW         = id_width(NREQ);
    localparam logic [ALEN-1:0] C_LAST_ADDR = '1;

    state_e          r_state_q,    w_state_d;
    logic [ALEN-1:0] r_cnt_q,      w_cnt_d;
    logic [IDW-1:0]  r_ptr_q,      w_ptr_d;
    logic            r_lock_vld_q, w_lock_vld_d;
    logic [IDW-1:0]  r_lock_id_q,  w_lock_id_d;
    logic [NREQ-1:0] r_rsp_vld_q,  w_rsp_vld_d;

    logic            w_run;
    logic            w_xfer;
    logic [NREQ-1:0] w_arb_valid;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gid;
    logic [IDW:0]    w_ptr_inc;
    logic [ALEN-1:0] w_addr  [NREQ];
    logic [DLEN-1:0] w_wdata [NREQ];

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_unpack
            assign w_addr[i]  = req_addr[i*ALEN +: ALEN];
            assign w_wdata[i] = req_wdata[i*DLEN +: DLEN];
        end
    endgenerate

    assign w_run       = (r_state_q == RUN);
    // Nobody can win arbitration while the sweep owns the RAM.
    assign w_arb_valid = w_run ? req_valid : '0;
    assign w_xfer      = |(w_grant & req_valid);

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .i_valid      (w_arb_valid),
        .i_ptr        (r_ptr_q),
        .i_lock_valid (r_lock_vld_q),
        .i_lock_id    (r_lock_id_q),
        .o_grant      (w_grant),
        .o_grant_id   (w_gid)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_ptr_d      = r_ptr_q;
        w_lock_vld_d = r_lock_vld_q;
        w_lock_id_d  = r_lock_id_q;
        w_rsp_vld_d  = '0;
        w_ptr_inc    = {1'b0, w_gid} + (IDW+1)'(1);
        req_ready    = '0;
        mem_wen      = 1'b0;
        mem_ren      = 1'b0;
        mem_waddr    = w_addr[w_gid];
        mem_wdata    = w_wdata[w_gid];
        mem_raddr    = w_addr[w_gid];
        case (r_state_q)
            INIT: begin
                mem_wen   = 1'b1;
                mem_waddr = r_cnt_q;
                mem_wdata = INIT_VALUE;
                w_cnt_d   = r_cnt_q + 1'b1;
                if (r_cnt_q == C_LAST_ADDR) begin
                    w_state_d = RUN;
                end
            end
            RUN: begin
                req_ready = w_grant;
                if (w_xfer) begin
                    if (req_we[w_gid]) begin
                        mem_wen = 1'b1;
                    end else begin
                        mem_ren     = 1'b1;
                        w_rsp_vld_d = w_grant;
                    end
                    w_ptr_d      = (w_ptr_inc == (IDW+1)'(NREQ)) ? '0 : w_ptr_inc[IDW-1:0];
                    w_lock_vld_d = req_lock[w_gid];
                    w_lock_id_d  = w_gid;
                end else begin
                    // No transfer means no requester is valid, so any owner has dropped.
                    w_lock_vld_d = 1'b0;
                end
            end
            default: begin
                w_state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q    <= INIT;
            r_cnt_q      <= '0;
            r_ptr_q      <= '0;
            r_lock_vld_q <= 1'b0;
            r_lock_id_q  <= '0;
            r_rsp_vld_q  <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_ptr_q      <= w_ptr_d;
            r_lock_vld_q <= w_lock_vld_d;
            r_lock_id_q  <= w_lock_id_d;
            r_rsp_vld_q  <= w_rsp_vld_d;
        end
    end

    // The RAM registers its read data, so it lines up with the registered id.
    assign rsp_valid = r_rsp_vld_q;
    assign rsp_rdata = mem_rdata;
    assign init_done = w_run;

endmodule
`default_nettype wire

// File: tb/tb_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_arbiter
// Brief    : Directed self-checking bench for bram_arbiter (NREQ=2, ALEN=4).
// Revision : 1.0
// ============================================================================
module tb_bram_arbiter;

    localparam int          NREQ = 2;
    localparam int          ALEN = 4;
    localparam int          DLEN = 32;
    localparam logic [31:0] IV   = 32'hDEAD_BEEF;
    localparam logic [31:0] D3   = 32'h1234_5678;
    localparam logic [31:0] D5   = 32'hAAAA_0005;

    // Lock scenario: valid vector, requester-1 lock bit, expected grant.
    localparam logic [1:0] LK_V [9] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b00};
    localparam logic       LK_L [9] = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
    localparam logic [1:0] LK_G [9] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b01, 2'b00};

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_we;
    logic [NREQ-1:0]      req_lock;
    logic [NREQ*ALEN-1:0] req_addr;
    logic [NREQ*DLEN-1:0] req_wdata;
    logic [NREQ-1:0]      rsp_valid;
    logic [DLEN-1:0]      rsp_rdata;
    logic                 init_done;
    logic                 mem_wen;
    logic [ALEN-1:0]      mem_waddr;
    logic [DLEN-1:0]      mem_wdata;
    logic                 mem_ren;
    logic [ALEN-1:0]      mem_raddr;
    logic [DLEN-1:0]      mem_rdata;

    logic [DLEN-1:0] ram [16];

    int total = 0;
    int bad   = 0;

    bram_arbiter #(
        .NREQ       (NREQ),
        .ALEN       (ALEN),
        .DLEN       (DLEN),
        .INIT_VALUE (IV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple registered-read RAM behind the arbiter.
    always @(posedge clk) begin
        if (mem_wen) ram[mem_waddr] <= mem_wdata;
        if (mem_ren) mem_rdata <= ram[mem_raddr];
    end

    task automatic idle();
        req_valid = '0;
        req_we    = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic drive(input int i, input logic we, input logic lk,
                         input logic [ALEN-1:0] a, input logic [DLEN-1:0] d);
        req_valid[i]            = 1'b1;
        req_we[i]               = we;
        req_lock[i]             = lk;
        req_addr[i*ALEN +: ALEN] = a;
        req_wdata[i*DLEN +: DLEN] = d;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        total++;
        if ({rsp_valid, init_done, req_ready} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outs: got %b want 00000", {rsp_valid, init_done, req_ready});
        end
        total++;
        if ({mem_wen, mem_ren, mem_waddr} !== {2'b10, 4'h0}) begin
            bad++;
            $display("FAIL reset_mem: got wen=%b ren=%b waddr=%0h want 1 0 0", mem_wen, mem_ren, mem_waddr);
        end
    endtask

    // Expects rst high on entry; releases it and follows the whole sweep.
    task automatic test_init_sweep();
        logic [ALEN-1:0] ea;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) begin
                rst = 1'b0;
                idle();
                req_valid = 2'b11;
            end
            #1;
            ea = i[ALEN-1:0];
            total++;
            if ({mem_wen, mem_ren, mem_waddr, mem_wdata} !== {2'b10, ea, IV}) begin
                bad++;
                $display("FAIL sweep[%0d]: got wen=%b ren=%b waddr=%0h wdata=%h want 1 0 %0h %h",
                         i, mem_wen, mem_ren, mem_waddr, mem_wdata, ea, IV);
            end
            total++;
            if ({init_done, req_ready} !== 3'b000) begin
                bad++;
                $display("FAIL sweep_busy[%0d]: got done=%b ready=%b want 0 00", i, init_done, req_ready);
            end
        end
        @(negedge clk);
        idle();
        #1;
        total++;
        if ({init_done, mem_wen, mem_ren, req_ready} !== 5'b10000) begin
            bad++;
            $display("FAIL sweep_end: got done=%b wen=%b ren=%b ready=%b want 1 0 0 00",
                     init_done, mem_wen, mem_ren, req_ready);
        end
    endtask

    task automatic test_read_init(input logic [ALEN-1:0] a);
        @(negedge clk);
        idle();
        drive(0, 1'b0, 1'b0, a, '0);
        #1;
        total++;
        if ({req_ready, mem_wen, mem_ren, mem_raddr} !== {2'b01, 2'b01, a}) begin
            bad++;
            $display("FAIL init_read_issue: got ready=%b wen=%b ren=%b raddr=%0h want 01 0 1 %0h",
                     req_ready, mem_wen, mem_ren, mem_raddr, a);
        end
        @(negedge clk);
        idle();
        #1;
        total++;
        if ({rsp_valid, rsp_rdata} !== {2'b01, IV}) begin
            bad++;
            $display("FAIL init_read_rsp: got v=%b d=%h want 01 %h", rsp_valid, rsp_rdata, IV);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        idle();
        drive(0, 1'b1, 1'b0, 4'd3, D3);
        #1;
        total++;
        if ({req_ready, mem_wen, mem_ren, mem_waddr, mem_wdata} !== {2'b01, 2'b10, 4'd3, D3}) begin
            bad++;
            $display("FAIL single_wr: got ready=%b wen=%b ren=%b waddr=%0h wdata=%h want 01 1 0 3 %h",
                     req_ready, mem_wen, mem_ren, mem_waddr, mem_wdata, D3);
        end
        @(negedge clk);
        idle();
        drive(0, 1'b0, 1'b0, 4'd3, '0);
        #1;
        total++;
        if ({req_ready, mem_wen, mem_ren, mem_raddr, rsp_valid} !== {2'b01, 2'b01, 4'd3, 2'b00}) begin
            bad++;
            $display("FAIL single_rd: got ready=%b wen=%b ren=%b raddr=%0h rspv=%b want 01 0 1 3 00",
                     req_ready, mem_wen, mem_ren, mem_raddr, rsp_valid);
        end
        @(negedge clk);
        idle();
        #1;
        total++;
        if ({rsp_valid, rsp_rdata, mem_wen, mem_ren} !== {2'b01, D3, 2'b00}) begin
            bad++;
            $display("FAIL single_rsp: got v=%b d=%h wen=%b ren=%b want 01 %h 0 0",
                     rsp_valid, rsp_rdata, mem_wen, mem_ren, D3);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0]      eg;
        logic [ALEN-1:0] ea;
        logic [DLEN-1:0] ed;
        // Requester 1 writes once so the pointer wraps back to requester 0.
        @(negedge clk);
        idle();
        drive(1, 1'b1, 1'b0, 4'd5, D5);
        #1;
        total++;
        if ({req_ready, mem_wen, mem_waddr, mem_wdata} !== {2'b10, 1'b1, 4'd5, D5}) begin
            bad++;
            $display("FAIL rr_prime: got ready=%b wen=%b waddr=%0h wdata=%h want 10 1 5 %h",
                     req_ready, mem_wen, mem_waddr, mem_wdata, D5);
        end
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            idle();
            if (c < 6) begin
                drive(0, 1'b0, 1'b0, 4'd3, '0);
                drive(1, 1'b0, 1'b0, 4'd5, '0);
            end
            #1;
            eg = (c >= 6) ? 2'b00 : ((c % 2 == 1) ? 2'b10 : 2'b01);
            ea = (c % 2 == 1) ? 4'd5 : 4'd3;
            total++;
            if (req_ready !== eg || (c < 6 && mem_raddr !== ea)) begin
                bad++;
                $display("FAIL rr_grant[%0d]: got ready=%b raddr=%0h want %b %0h", c, req_ready, mem_raddr, eg, ea);
            end
            if (c > 0) begin
                eg = (c % 2 == 0) ? 2'b10 : 2'b01;
                ed = (c % 2 == 0) ? D5 : D3;
                total++;
                if ({rsp_valid, rsp_rdata} !== {eg, ed}) begin
                    bad++;
                    $display("FAIL rr_rsp[%0d]: got v=%b d=%h want %b %h", c, rsp_valid, rsp_rdata, eg, ed);
                end
            end
        end
    endtask

    task automatic test_lock();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            idle();
            if (LK_V[c][0]) drive(0, 1'b0, 1'b0, 4'd3, '0);
            if (LK_V[c][1]) drive(1, 1'b0, LK_L[c], 4'd5, '0);
            #1;
            total++;
            if (req_ready !== LK_G[c]) begin
                bad++;
                $display("FAIL lock_grant[%0d]: got %b want %b", c, req_ready, LK_G[c]);
            end
            if (c > 0) begin
                total++;
                if (rsp_valid !== LK_G[c-1]) begin
                    bad++;
                    $display("FAIL lock_rsp[%0d]: got %b want %b", c, rsp_valid, LK_G[c-1]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [ALEN-1:0] ea;
        @(negedge clk);
        idle();
        drive(0, 1'b0, 1'b0, 4'd3, '0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        idle();
        #1;
        total++;
        if ({rsp_valid, init_done, req_ready, mem_wen, mem_ren, mem_waddr} !== {5'b0, 2'b10, 4'd0}) begin
            bad++;
            $display("FAIL mid_rd_reset: got rspv=%b done=%b ready=%b wen=%b ren=%b waddr=%0h want 00 0 00 1 0 0",
                     rsp_valid, init_done, req_ready, mem_wen, mem_ren, mem_waddr);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) rst = 1'b0;
            #1;
            ea = i[ALEN-1:0];
            total++;
            if (mem_waddr !== ea || init_done !== 1'b0) begin
                bad++;
                $display("FAIL mid_sweep[%0d]: got waddr=%0h done=%b want %0h 0", i, mem_waddr, init_done, ea);
            end
        end
        rst = 1'b1;
        #1;
        total++;
        if ({mem_wen, mem_waddr, init_done, rsp_valid} !== {1'b1, 4'd0, 3'b000}) begin
            bad++;
            $display("FAIL mid_sweep_reset: got wen=%b waddr=%0h done=%b rspv=%b want 1 0 0 00",
                     mem_wen, mem_waddr, init_done, rsp_valid);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_init_sweep();
        test_read_init(4'd7);
        test_single();
        test_round_robin();
        test_lock();
        test_reset_mid();
        test_init_sweep();
        // Address 3 held D3 before the reset; the fresh sweep must have cleared it.
        test_read_init(4'd3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
